pipemem_arbiter: RTL and testbench
==================================

PIPEMEM_ARBITER -- requirements
Module: pipemem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of memory wait cycles before forced completion.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports i_req in 1, i_addr in 32: instruction-fetch read request and word address.
REQ-005 SHALL have ports i_rdata out 32, i_done out 1: fetched word and one-cycle completion pulse.
REQ-006 SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32: data-stage request, write enable, address, store data.
REQ-007 SHALL have ports d_rdata out 32, d_done out 1: load data and one-cycle completion pulse.
REQ-008 SHALL have ports m_req out 1, m_we out 1, m_addr out 32, m_wdata out 32: single-port memory request bus.
REQ-009 SHALL have ports m_rdata in 32, m_ack in 1: memory read data and acknowledge, valid in the same cycle.
REQ-010 SHALL have ports stall out 1 (pipeline freeze) and err out 1 (sticky timeout flag).

Function
REQ-011 SHALL implement states IDLE, DBUSY, IBUSY, RESP.
REQ-012 In IDLE with d_req=1 and (i_req=0 or ifirst=0), SHALL latch d_we/d_addr/d_wdata and go to DBUSY.
REQ-013 In IDLE with i_req=1 and (d_req=0 or ifirst=1), SHALL latch i_addr and go to IBUSY.
REQ-014 ifirst SHALL be set when a D grant is made while i_req=1, and cleared on any I grant; anti-starvation rule.
REQ-015 In DBUSY/IBUSY, m_req SHALL be 1 and m_we/m_addr/m_wdata SHALL come from latched registers, stable until ack; m_we=0 in IBUSY.
REQ-016 On m_ack=1 in DBUSY/IBUSY, SHALL register m_rdata into d_rdata or i_rdata respectively and go to RESP.
REQ-017 In RESP, exactly one of d_done/i_done SHALL be 1 for that single cycle; next state IDLE unconditionally; requests are not sampled in RESP.
REQ-018 i_rdata/d_rdata SHALL hold their value until the next completion on the same port.
REQ-019 For a store (d_we=1), d_rdata SHALL be unchanged; d_done still pulses.
REQ-020 A wait counter SHALL clear on entering DBUSY/IBUSY and increment each non-ack cycle; when it reaches TIMEOUT, SHALL set err, force rdata to 0, go to RESP.
REQ-021 m_ack in the same cycle the counter reaches TIMEOUT SHALL take precedence (normal completion, err unchanged).
REQ-022 m_ack outside DBUSY/IBUSY SHALL be ignored.
REQ-023 stall SHALL be combinational: (i_req & ~i_done) | (d_req & ~d_done).
REQ-024 Requesters SHALL hold req and operands stable until their done; arbiter behaviour on violation is undefined.
REQ-025 Minimum latency: request sampled in IDLE at cycle N, m_ack at N+1, done at N+2.

Reset
REQ-026 resetn=0 SHALL immediately force state IDLE, m_req=0, m_we=0, i_done=0, d_done=0, err=0, ifirst=0, counter=0, i_rdata=0, d_rdata=0, m_addr=0, m_wdata=0.
REQ-027 Reset during DBUSY/IBUSY SHALL abandon the transaction with no done pulse; memory side tolerates the dropped m_req.

Structure
REQ-028 State encoding (2-bit IDLE=0, DBUSY=1, IBUSY=2, RESP=3) and the TIMEOUT default SHALL reside in a shared package used by pipeline modules.
REQ-029 Counter width SHALL be clog2(TIMEOUT+1); one sub-module pipemem_wait_timer (clear, enable, expired) is natural; FSM and latches stay in top.

Verification
REQ-030 Single fetch: i_req=1, i_addr=0x40, m_ack one cycle later with m_rdata=0x8C010004 -> i_done pulse, i_rdata=0x8C010004, stall high until done.
REQ-031 Simultaneous: i_req and d_req (load 0x100) from reset -> D served first, then I served next with ifirst honoured; two done pulses, no overlap.
REQ-032 Store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, ack after 3 wait cycles -> m_we=1 with stable bus for 4 cycles, d_done pulse, d_rdata unchanged.
REQ-033 Timeout: TIMEOUT=4, no m_ack -> RESP after 4 wait cycles, err=1 sticky, rdata=0; ack on 4th cycle instead -> err stays 0.
REQ-034 Reset mid-DBUSY: resetn low for 1 cycle -> m_req=0 same cycle, no d_done, state IDLE.
REQ-035 Starvation: d_req held through back-to-back loads with i_req=1 -> grants alternate D, I, D, I.

Source files
------------

// File: rtl/pipemem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Pipeline stages import this to decode the arbiter state.
package pipemem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DBUSY = 2'd1,
    IBUSY = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int TIMEOUT_DEFAULT = 255;

  function automatic logic is_busy(
    input arb_state_t s
  );
    return (s == DBUSY) || (s == IBUSY);
  endfunction

endpackage

// File: rtl/pipemem_wait_timer.sv
// Memory wait counter; flags the cycle in which
// the count would reach TIMEOUT without an ack.
module pipemem_wait_timer
  import pipemem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  assign expired = enable && (count == LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipemem_arbiter.sv
// Single-port memory arbiter between fetch and data stages,
// with fetch anti-starvation and a wait timeout.
module pipemem_arbiter
  import pipemem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        stall,
  output logic        err
);

  arb_state_t state, state_nxt;

  logic ifirst;
  logic we;
  logic dport;
  logic busy;
  logic expired;
  logic grant_d;
  logic grant_i;

  assign busy   = is_busy(state);
  assign m_req  = busy;
  assign m_we   = (state == DBUSY) && we;
  assign d_done = (state == RESP) && dport;
  assign i_done = (state == RESP) && !dport;
  assign stall  = (i_req && !i_done)
                || (d_req && !d_done);

  pipemem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .resetn (resetn),
    .clear  (!busy),
    .enable (busy && !m_ack),
    .expired(expired)
  );

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    unique case (state)
      IDLE: begin
        grant_d = d_req && (!i_req || !ifirst);
        grant_i = i_req && !grant_d;
        if (grant_d) begin
          state_nxt = DBUSY;
        end else if (grant_i) begin
          state_nxt = IBUSY;
        end
      end
      DBUSY, IBUSY: begin
        if (m_ack || expired) begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      ifirst  <= 1'b0;
      we      <= 1'b0;
      dport   <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        we      <= d_we;
        dport   <= 1'b1;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        if (i_req) begin
          ifirst <= 1'b1;
        end
      end
      if (grant_i) begin
        we     <= 1'b0;
        dport  <= 1'b0;
        m_addr <= i_addr;
        ifirst <= 1'b0;
      end
      // expired is never raised alongside m_ack, so ack wins
      if (busy && (m_ack || expired)) begin
        if (expired) begin
          err <= 1'b1;
        end
        if (state == IBUSY) begin
          i_rdata <= m_ack ? m_rdata : '0;
        end else if (!we) begin
          d_rdata <= m_ack ? m_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipemem_arbiter.sv
// Self-checking bench: directed vectors, corner sequences,
// and random multi-request scenarios against a transaction model.
module tb_pipemem_arbiter;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic        stall;
  logic        err;

  int n_checks = 0;
  int n_err = 0;

  logic [31:0] md_rdata;
  logic [31:0] mi_rdata;
  bit          m_err_exp;
  bit          m_owed;

  always #5 clock = ~clock;

  pipemem_arbiter #(
    .TIMEOUT(TO)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_done (i_done),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_done (d_done),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ack  (m_ack),
    .stall  (stall),
    .err    (err)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waitc;
    int          lat;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dtx_t;

  vec_t vecs [8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name,
                         input string act,
                         input string exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    md_rdata  = '0;
    mi_rdata  = '0;
    m_err_exp = 1'b0;
    m_owed    = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    i_req  = 1'b0;
    d_req  = 1'b0;
    m_ack  = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int k;
    bit got;
    string tag;
    lat = 0;
    k = 0;
    got = 1'b0;
    tag = $sformatf("vec%0d", idx);
    if (v.is_d) begin
      d_req = 1'b1;
      d_we = v.we;
      d_addr = v.addr;
      d_wdata = v.wdata;
    end else begin
      i_req = 1'b1;
      i_addr = v.addr;
    end
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (i_done || d_done) begin
        got = 1'b1;
      end else begin
        if (m_req) begin
          k++;
          chk({tag, "_m_we"}, m_we, v.is_d && v.we);
          chk({tag, "_m_addr"}, m_addr, v.addr);
          if (v.is_d) chk({tag, "_m_wdata"}, m_wdata, v.wdata);
          m_ack = (k == v.waitc + 1);
          if (m_ack) m_rdata = v.rdata;
          else m_rdata = $urandom;
        end else begin
          m_ack = 1'b0;
        end
        #1;
        chk({tag, "_stall"}, stall, 1);
      end
    end
    chk({tag, "_got_done"}, got, 1);
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_d_done"}, d_done, v.is_d);
    chk({tag, "_i_done"}, i_done, !v.is_d);
    if (v.is_d) chk({tag, "_d_rdata"}, d_rdata, v.exp_rdata);
    else chk({tag, "_i_rdata"}, i_rdata, v.exp_rdata);
    chk({tag, "_err"}, err, v.exp_err);
    i_req = 1'b0;
    d_req = 1'b0;
    m_ack = 1'b0;
    tick();
  endtask

  task automatic run_scen(input int nd, input int ni,
                          input int max_w, output string order);
    dtx_t dq [$];
    logic [31:0] iq [$];
    bit exp_g [$];
    dtx_t t;
    logic [31:0] r;
    int a, b, dh, ih, cyc, budget, mcnt, mw;
    bit owed, mact, cur_d, pend, pend_d, pend_to;
    bit this_d, this_i;
    logic [31:0] pend_val;
    order = "";
    for (int n = 0; n < nd; n++) begin
      r = $urandom;
      t.we = ($urandom_range(1, 0) == 1);
      t.addr = {4'h1, r[27:2], 2'b00};
      t.wdata = $urandom;
      dq.push_back(t);
    end
    for (int n = 0; n < ni; n++) begin
      r = $urandom;
      iq.push_back({4'h0, r[27:2], 2'b00});
    end
    a = nd;
    b = ni;
    owed = m_owed;
    while (a > 0 || b > 0) begin
      if (a > 0 && (b == 0 || !owed)) begin
        exp_g.push_back(1'b1);
        if (b > 0) owed = 1'b1;
        a--;
      end else begin
        exp_g.push_back(1'b0);
        owed = 1'b0;
        b--;
      end
    end
    m_owed = owed;
    dh = 0;
    ih = 0;
    mact = 1'b0;
    pend = 1'b0;
    pend_d = 1'b0;
    pend_to = 1'b0;
    pend_val = '0;
    cur_d = 1'b0;
    mcnt = 0;
    mw = 0;
    cyc = 0;
    budget = (nd + ni) * (TO + 6) + 10;
    d_req = (dh < nd);
    if (dh < nd) begin
      d_we = dq[dh].we;
      d_addr = dq[dh].addr;
      d_wdata = dq[dh].wdata;
    end
    i_req = (ih < ni);
    if (ih < ni) i_addr = iq[ih];
    while ((dh < nd || ih < ni || pend) && cyc < budget) begin
      tick();
      cyc++;
      if (d_done) order = {order, "D"};
      if (i_done) order = {order, "I"};
      this_d = 1'b0;
      this_i = 1'b0;
      if (pend) begin
        this_d = pend_d;
        this_i = !pend_d;
        chk("sc_d_done", d_done, pend_d);
        chk("sc_i_done", i_done, !pend_d);
        if (pend_d) begin
          if (dh < nd && !dq[dh].we) md_rdata = pend_val;
          dh++;
        end else begin
          mi_rdata = pend_val;
          ih++;
        end
        if (pend_to) m_err_exp = 1'b1;
        chk("sc_d_rdata", d_rdata, md_rdata);
        chk("sc_i_rdata", i_rdata, mi_rdata);
        pend = 1'b0;
      end else begin
        chk("sc_no_done", {d_done, i_done}, 0);
      end
      chk("sc_err", err, m_err_exp);
      if (m_req) begin
        if (!mact) begin
          mact = 1'b1;
          mcnt = 0;
          mw = $urandom_range(max_w, 0);
          if (exp_g.size() == 0) begin
            chk("sc_extra_grant", 1, 0);
            cur_d = 1'b0;
          end else begin
            cur_d = exp_g.pop_front();
          end
        end
        if (cur_d && dh < nd) begin
          chk("sc_d_m_we", m_we, dq[dh].we);
          chk("sc_d_m_addr", m_addr, dq[dh].addr);
          chk("sc_d_m_wdata", m_wdata, dq[dh].wdata);
        end else if (!cur_d && ih < ni) begin
          chk("sc_i_m_we", m_we, 0);
          chk("sc_i_m_addr", m_addr, iq[ih]);
        end
        mcnt++;
        m_rdata = $urandom;
        m_ack = (mcnt == mw + 1);
        if (m_ack || mcnt == TO) begin
          pend = 1'b1;
          pend_d = cur_d;
          pend_to = !m_ack;
          if (m_ack) pend_val = m_rdata;
          else pend_val = '0;
          mact = 1'b0;
        end
      end else begin
        m_ack = ($urandom_range(1, 0) == 1);
        m_rdata = $urandom;
      end
      d_req = (dh < nd);
      if (dh < nd) begin
        d_we = dq[dh].we;
        d_addr = dq[dh].addr;
        d_wdata = dq[dh].wdata;
      end
      i_req = (ih < ni);
      if (ih < ni) i_addr = iq[ih];
      #1;
      chk("sc_stall", stall,
          ((dh < nd) && !this_d) || ((ih < ni) && !this_i));
    end
    if (dh < nd || ih < ni || pend) chk("sc_budget", 0, 1);
    d_req = 1'b0;
    i_req = 1'b0;
    m_ack = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string ord;
    int nd;
    int ni;

    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h8C010004,
                0, 2, 32'h8C010004, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h12345678,
                1, 3, 32'h12345678, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 32'hFFFFFFFF,
                3, 5, 32'h12345678, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h44,  32'h0,        32'hA5A5A5A5,
                2, 4, 32'hA5A5A5A5, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h300, 32'h0,        32'h0BADF00D,
                3, 5, 32'h0BADF00D, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h48,  32'h0,        32'h77777777,
                9, 5, 32'h0,        1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h304, 32'h0,        32'h11112222,
                0, 2, 32'h11112222, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h308, 32'h0,        32'h33334444,
                7, 5, 32'h0,        1'b1};

    model_reset();
    repeat (2) tick();
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_err", err, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_stall", stall, 0);
    resetn = 1'b1;
    tick();

    m_ack = 1'b1;
    m_rdata = 32'hCAFEF00D;
    repeat (2) begin
      tick();
      chk("idle_ack_done", {d_done, i_done}, 0);
      chk("idle_ack_m_req", m_req, 0);
      chk("idle_ack_d_rdata", d_rdata, 0);
    end
    m_ack = 1'b0;

    for (int v = 0; v < 8; v++) run_vec(vecs[v], v);

    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h100;
    m_ack = 1'b0;
    tick();
    tick();
    chk("midrst_pre_m_req", m_req, 1);
    resetn = 1'b0;
    #1;
    chk("midrst_m_req", m_req, 0);
    chk("midrst_d_done", d_done, 0);
    chk("midrst_m_addr", m_addr, 0);
    chk("midrst_err", err, 0);
    tick();
    chk("midrst_hold_done", d_done, 0);
    resetn = 1'b1;
    d_req = 1'b0;
    model_reset();
    repeat (3) begin
      tick();
      chk("midrst_after_done", {d_done, i_done}, 0);
      chk("midrst_after_m_req", m_req, 0);
    end

    do_reset();
    run_scen(1, 1, 0, ord);
    chk_str("simul_order", ord, "DI");

    do_reset();
    run_scen(3, 2, 1, ord);
    chk_str("starve_order", ord, "DIDID");

    do_reset();
    for (int s = 0; s < 120; s++) begin
      nd = $urandom_range(3, 0);
      ni = $urandom_range(3, 0);
      if (nd + ni == 0) nd = 1;
      run_scen(nd, ni, (s < 60) ? 3 : 5, ord);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
